exc_commit: RTL and testbench

EXC_COMMIT -- requirements
Module: exc_commit

---
 rtl/exc_commit.sv | 108 ++++++++++
 tb/tb_exc_commit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/exc_commit.sv
// exc_commit: dual-issue commit stage that picks the oldest exception, interrupt or ERET,
// updates the CP0 exception registers and issues a one-cycle flush with a new fetch PC.
module exc_commit #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        m_valid,
   input  logic        s_valid,
   input  logic [31:0] m_pc,
   input  logic [31:0] s_pc,
   input  logic        m_bd,
   input  logic        s_bd,
   input  logic [7:0]  m_exc,
   input  logic [7:0]  s_exc,
   input  logic        m_eret,
   input  logic        s_eret,
   input  logic [31:0] m_badva,
   input  logic [31:0] s_badva,
   input  logic        int_pending,
   output logic        m_commit,
   output logic        s_commit,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [31:0] epc,
   output logic        exl,
   output logic        cause_bd,
   output logic [4:0]  exc_code,
   output logic [31:0] badvaddr
);
   typedef enum logic {IDLE, FLUSH} state_t;
   state_t      r_state, w_next;
   logic        r_flush, r_exl, r_bd;
   logic [31:0] r_redirect, r_epc, r_badvaddr;
   logic [4:0]  r_code;
   logic        w_active, w_int, w_mi, w_si, w_me, w_se, w_mexc, w_sexc, w_mev, w_sev;
   logic        w_i, w_bd, w_isexc, w_fire;
   logic [7:0]  w_mx, w_sx, w_x;
   logic [31:0] w_pc, w_ba, w_bva, w_epc;
   logic [4:0]  w_code;
   always_comb begin
      w_active = (r_state == IDLE) & ~stall & ~rst;
      w_mx     = m_valid ? m_exc : 8'h00;
      w_sx     = s_valid ? s_exc : 8'h00;
      w_me     = m_valid & m_eret;
      w_se     = s_valid & s_eret;
      w_int    = int_pending & ~r_exl & (m_valid | s_valid);
      w_mi     = w_int & m_valid;
      w_si     = w_int & ~m_valid;
      w_mexc   = w_mi | (|w_mx);
      w_sexc   = w_si | (|w_sx);
      w_mev    = w_mexc | w_me;
      w_sev    = w_sexc | w_se;
      w_i      = w_mev ? w_mi : w_si;
      w_x      = w_mev ? w_mx : w_sx;
      w_pc     = w_mev ? m_pc : s_pc;
      w_bd     = w_mev ? m_bd : s_bd;
      w_ba     = w_mev ? m_badva : s_badva;
      w_isexc  = w_mev ? w_mexc : w_sexc;
      w_fire   = w_active & (w_mev | w_sev);
      w_code   = w_i    ? 5'd0  : w_x[7] ? 5'd4  : w_x[6] ? 5'd10 : w_x[5] ? 5'd8 :
                 w_x[4] ? 5'd9  : w_x[3] ? 5'd12 : w_x[2] ? 5'd13 : w_x[1] ? 5'd4 : 5'd5;
      w_bva    = w_i ? r_badvaddr : w_x[7] ? w_pc :
                 (w_x[6:2] == 5'd0 && w_x[1:0] != 2'd0) ? w_ba : r_badvaddr;
      w_epc    = w_bd ? w_pc - 32'd4 : w_pc;
      m_commit = w_active & m_valid & ~w_mev;
      s_commit = w_active & s_valid & ~w_sev & ~w_mev;
   end
   always_comb begin
      w_next = IDLE;
      if (r_state == IDLE && w_fire) w_next = FLUSH;
   end
   always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush    <= 1'b0;
         r_redirect <= 32'h0;
         r_epc      <= 32'h0;
         r_badvaddr <= 32'h0;
         r_code     <= 5'd0;
         r_bd       <= 1'b0;
         r_exl      <= 1'b1;
      end else begin
         r_flush <= w_fire;
         if (w_fire && w_isexc) begin
            r_redirect <= EXC_VECTOR;
            r_code     <= w_code;
            r_badvaddr <= w_bva;
            r_exl      <= 1'b1;
            if (!r_exl) begin
               r_epc <= w_epc;
               r_bd  <= w_bd;
            end
         end else if (w_fire) begin
            r_redirect <= r_epc;
            r_exl      <= 1'b0;
         end
      end
   end
   assign flush       = r_flush;
   assign redirect_pc = r_redirect;
   assign epc         = r_epc;
   assign exl         = r_exl;
   assign cause_bd    = r_bd;
   assign exc_code    = r_code;
   assign badvaddr    = r_badvaddr;
endmodule

// File: tb/tb_exc_commit.sv
// tb_exc_commit: vector table with a scoreboard queue of expected register state,
// plus hand sequences for stall, event-during-flush and reset-during-flush.
module tb_exc_commit;
   logic        clk = 0, rst, stall, m_valid, s_valid, m_bd, s_bd, m_eret, s_eret, int_pending;
   logic [31:0] m_pc, s_pc, m_badva, s_badva;
   logic [7:0]  m_exc, s_exc;
   logic        m_commit, s_commit, flush, exl, cause_bd;
   logic [31:0] redirect_pc, epc, badvaddr;
   logic [4:0]  exc_code;
   int errors = 0, checks = 0;

   exc_commit dut (
      .clk(clk), .rst(rst), .stall(stall), .m_valid(m_valid), .s_valid(s_valid),
      .m_pc(m_pc), .s_pc(s_pc), .m_bd(m_bd), .s_bd(s_bd), .m_exc(m_exc), .s_exc(s_exc),
      .m_eret(m_eret), .s_eret(s_eret), .m_badva(m_badva), .s_badva(s_badva),
      .int_pending(int_pending), .m_commit(m_commit), .s_commit(s_commit), .flush(flush),
      .redirect_pc(redirect_pc), .epc(epc), .exl(exl), .cause_bd(cause_bd),
      .exc_code(exc_code), .badvaddr(badvaddr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic mv, sv; logic [31:0] mpc, spc; logic mbd, sbd; logic [7:0] mx, sx;
      logic me, se; logic [31:0] mba, sba; logic ip;
      logic emc, esc, efl; logic [31:0] erd, eepc; logic eexl, ebd; logic [4:0] ecode;
      logic [31:0] ebva;
   } vec_t;
   typedef struct {
      logic efl; logic [31:0] erd, eepc; logic eexl, ebd; logic [4:0] ecode; logic [31:0] ebva;
   } exp_t;

   vec_t t[19];
   exp_t q[$];
   exp_t e;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, x);
      end
   endtask

   task automatic idle();
      stall = 0; m_valid = 0; s_valid = 0; m_pc = 0; s_pc = 0; m_bd = 0; s_bd = 0;
      m_exc = 0; s_exc = 0; m_eret = 0; s_eret = 0; m_badva = 0; s_badva = 0; int_pending = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      t[0]  = '{1,0,32'h0,32'h0,0,0,8'h00,8'h00,1,0,32'h0,32'h0,0, 0,0, 1,32'h0,32'h0,0,0,5'd0,32'h0};
      t[1]  = '{1,1,32'h80000100,32'h80000104,0,0,8'h04,8'h00,0,0,32'h0,32'h0,0, 0,0, 1,32'hBFC00380,32'h80000100,1,0,5'd13,32'h0};
      t[2]  = '{1,0,32'h0,32'h0,0,0,8'h00,8'h00,1,0,32'h0,32'h0,0, 0,0, 1,32'h80000100,32'h80000100,0,0,5'd13,32'h0};
      t[3]  = '{1,1,32'h80000200,32'h80000204,0,1,8'h00,8'h40,0,0,32'h0,32'h0,0, 1,0, 1,32'hBFC00380,32'h80000200,1,1,5'd10,32'h0};
      t[4]  = '{1,0,32'h80000500,32'h0,0,0,8'h0C,8'h00,0,0,32'h0,32'h0,0, 0,0, 1,32'hBFC00380,32'h80000200,1,1,5'd12,32'h0};
      t[5]  = '{1,1,32'h80000510,32'h80000514,0,0,8'h00,8'h00,0,0,32'h0,32'h0,0, 1,1, 0,32'hBFC00380,32'h80000200,1,1,5'd12,32'h0};
      t[6]  = '{1,0,32'h0,32'h0,0,0,8'h00,8'h00,1,0,32'h0,32'h0,0, 0,0, 1,32'h80000200,32'h80000200,0,1,5'd12,32'h0};
      t[7]  = '{1,0,32'h80000600,32'h0,0,0,8'h0C,8'h00,0,0,32'h0,32'h0,0, 0,0, 1,32'hBFC00380,32'h80000600,1,0,5'd12,32'h0};
      t[8]  = '{1,0,32'h0,32'h0,0,0,8'h00,8'h00,1,0,32'h0,32'h0,0, 0,0, 1,32'h80000600,32'h80000600,0,0,5'd12,32'h0};
      t[9]  = '{0,1,32'h0,32'h80000300,0,0,8'h00,8'h00,0,0,32'h0,32'h0,1, 0,0, 1,32'hBFC00380,32'h80000300,1,0,5'd0,32'h0};
      t[10] = '{1,1,32'h80000310,32'h80000314,0,0,8'h00,8'h00,0,0,32'h0,32'h0,1, 1,1, 0,32'hBFC00380,32'h80000300,1,0,5'd0,32'h0};
      t[11] = '{1,0,32'h80000700,32'h0,0,0,8'h80,8'h00,0,0,32'hDEAD0000,32'h0,0, 0,0, 1,32'hBFC00380,32'h80000300,1,0,5'd4,32'h80000700};
      t[12] = '{1,1,32'h80000710,32'h80000714,0,0,8'h00,8'h01,0,0,32'h0,32'h12345678,0, 1,0, 1,32'hBFC00380,32'h80000300,1,0,5'd5,32'h12345678};
      t[13] = '{0,0,32'h80000720,32'h80000724,0,0,8'hFF,8'hFF,1,1,32'h0,32'h0,0, 0,0, 0,32'hBFC00380,32'h80000300,1,0,5'd5,32'h12345678};
      t[14] = '{1,0,32'h0,32'h0,0,0,8'h00,8'h00,1,0,32'h0,32'h0,0, 0,0, 1,32'h80000300,32'h80000300,0,0,5'd5,32'h12345678};
      t[15] = '{1,1,32'h0,32'h4,1,0,8'h20,8'h40,0,0,32'h0,32'h0,0, 0,0, 1,32'hBFC00380,32'hFFFFFFFC,1,1,5'd8,32'h12345678};
      t[16] = '{1,0,32'h0,32'h0,0,0,8'h00,8'h00,1,0,32'h0,32'h0,0, 0,0, 1,32'hFFFFFFFC,32'hFFFFFFFC,0,1,5'd8,32'h12345678};
      t[17] = '{1,1,32'h80000800,32'h80000804,0,0,8'h10,8'h80,0,0,32'h0,32'h0,0, 0,0, 1,32'hBFC00380,32'h80000800,1,0,5'd9,32'h12345678};
      t[18] = '{1,0,32'h80000810,32'h0,0,0,8'h02,8'h00,0,0,32'hCAFE0000,32'h0,0, 0,0, 1,32'hBFC00380,32'h80000800,1,0,5'd4,32'hCAFE0000};

      idle();
      rst = 1;
      m_valid = 1;
      s_valid = 1;
      step();
      chk("rst_m_commit", m_commit, 0);
      chk("rst_s_commit", s_commit, 0);
      step();
      idle();
      rst = 0;
      chk("rst_flush", flush, 0);
      chk("rst_redirect", redirect_pc, 0);
      chk("rst_epc", epc, 0);
      chk("rst_badvaddr", badvaddr, 0);
      chk("rst_code", exc_code, 0);
      chk("rst_bd", cause_bd, 0);
      chk("rst_exl", exl, 1);

      for (int i = 0; i < 19; i++) begin
         m_valid = t[i].mv; s_valid = t[i].sv; m_pc = t[i].mpc; s_pc = t[i].spc;
         m_bd = t[i].mbd; s_bd = t[i].sbd; m_exc = t[i].mx; s_exc = t[i].sx;
         m_eret = t[i].me; s_eret = t[i].se; m_badva = t[i].mba; s_badva = t[i].sba;
         int_pending = t[i].ip;
         q.push_back('{t[i].efl, t[i].erd, t[i].eepc, t[i].eexl, t[i].ebd, t[i].ecode, t[i].ebva});
         #1;
         chk($sformatf("v%0d_m_commit", i), m_commit, t[i].emc);
         chk($sformatf("v%0d_s_commit", i), s_commit, t[i].esc);
         step();
         idle();
         e = q.pop_front();
         chk($sformatf("v%0d_flush", i), flush, e.efl);
         chk($sformatf("v%0d_redirect", i), redirect_pc, e.erd);
         chk($sformatf("v%0d_epc", i), epc, e.eepc);
         chk($sformatf("v%0d_exl", i), exl, e.eexl);
         chk($sformatf("v%0d_bd", i), cause_bd, e.ebd);
         chk($sformatf("v%0d_code", i), exc_code, e.ecode);
         chk($sformatf("v%0d_badvaddr", i), badvaddr, e.ebva);
         step();
         chk($sformatf("v%0d_flush_drop", i), flush, 0);
      end

      m_valid = 1; m_eret = 1;
      step();
      idle();
      chk("eret_flush", flush, 1);
      chk("eret_redirect", redirect_pc, 32'h80000800);
      chk("eret_exl", exl, 0);
      step();

      s_valid = 1; s_pc = 32'h80000300; int_pending = 1; stall = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_s_commit", s_commit, 0);
         step();
         chk("stall_flush", flush, 0);
      end
      stall = 0;
      #1;
      chk("unstall_s_commit", s_commit, 0);
      step();
      chk("unstall_flush", flush, 1);
      chk("unstall_code", exc_code, 0);
      chk("unstall_epc", epc, 32'h80000300);

      idle();
      m_valid = 1; m_pc = 32'h80000A00; m_exc = 8'h08;
      #1;
      chk("inflush_m_commit", m_commit, 0);
      step();
      idle();
      chk("inflush_flush", flush, 0);
      chk("inflush_code", exc_code, 0);

      m_valid = 1; m_pc = 32'h80000900; m_exc = 8'h04;
      step();
      idle();
      chk("pre_rst_flush", flush, 1);
      chk("pre_rst_code", exc_code, 13);
      chk("pre_rst_epc", epc, 32'h80000300);
      rst = 1; m_valid = 1; s_valid = 1;
      #1;
      chk("rstflush_m_commit", m_commit, 0);
      chk("rstflush_s_commit", s_commit, 0);
      step();
      rst = 0;
      idle();
      chk("rstflush_flush", flush, 0);
      chk("rstflush_epc", epc, 0);
      chk("rstflush_exl", exl, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
